dice_roll_ctrl: RTL and testbench

Sequences a modulo-FACES face counter to produce one die roll per request. While `roll` is held, the face advances every clock. On release, the face keeps advancing with exponentially growing intervals (the "deceleration"), then stops. It then reports the result with a one-cycle `done` pulse. The block sits between the debounced roll button and the face display / result consumers.

---
 rtl/dice_roll_ctrl.sv | 137 +++++++++++++
 tb/tb_dice_roll_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dice_roll_ctrl.sv
// Die-roll sequencer: spins a modulo-FACES face while roll is held, then slows down and stops.
// Latency: face/step/busy/done are registered and change one edge after the event that causes them.
// No backpressure: roll is ignored during the slow-down; a held roll restarts one cycle after done.
module dice_roll_ctrl #(
  parameter int FACES      = 6,
  parameter int BUS_SIZE   = 4,
  parameter int SLOW_STEPS = 4,
  parameter int DIV_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                roll,
  output logic [BUS_SIZE-1:0] face,
  output logic                step,
  output logic                busy,
  output logic                done
);

  localparam int STEP_W = (SLOW_STEPS < 2) ? 1 : $clog2(SLOW_STEPS + 1);

  localparam logic [BUS_SIZE-1:0] LAST_IDX  = BUS_SIZE'(FACES - 1);
  localparam logic [BUS_SIZE-1:0] ONE_B     = BUS_SIZE'(1);
  localparam logic [STEP_W-1:0]   LAST_STEP = STEP_W'(SLOW_STEPS - 1);
  localparam logic [STEP_W-1:0]   ONE_S     = STEP_W'(1);
  localparam logic [DIV_W-1:0]    ONE_D     = DIV_W'(1);
  localparam logic [DIV_W-1:0]    TWO_D     = DIV_W'(2);

  typedef enum logic [1:0] {IDLE, SPIN, SLOW, DONE} state_t;

  state_t              state, state_n;
  logic [BUS_SIZE-1:0] idx, idx_n, idx_adv;
  logic [DIV_W-1:0]    tick, tick_n;
  logic [DIV_W-1:0]    interval, interval_n;
  logic [STEP_W-1:0]   steps, steps_n;
  logic [BUS_SIZE-1:0] face_n;
  logic                step_n, busy_n, done_n;

  // Wrap-around successor of the current face index.
  always_comb begin
    idx_adv = (idx == LAST_IDX) ? '0 : idx + ONE_B;
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    tick_n     = tick;
    interval_n = interval;
    steps_n    = steps;
    face_n     = face;
    step_n     = 1'b0;
    busy_n     = busy;
    done_n     = 1'b0;

    case (state)
      IDLE: begin
        // Free-running index: the human's press timing supplies the randomness.
        idx_n  = idx_adv;
        busy_n = 1'b0;
        if (roll) begin
          state_n = SPIN;
          busy_n  = 1'b1;
        end
      end

      SPIN: begin
        if (roll) begin
          idx_n  = idx_adv;
          face_n = idx_adv + ONE_B;
          step_n = 1'b1;
        end else begin
          state_n    = SLOW;
          interval_n = TWO_D;
          tick_n     = '0;
          steps_n    = '0;
        end
      end

      SLOW: begin
        if (tick == interval - ONE_D) begin
          idx_n   = idx_adv;
          face_n  = idx_adv + ONE_B;
          tick_n  = '0;
          steps_n = steps + ONE_S;
          // Doubling stops once the top bit is set, which is the saturation value.
          interval_n = interval[DIV_W-1] ? interval : (interval << 1);
          if (steps == LAST_STEP) begin
            // The final advance is reported by done rather than step so the two never overlap.
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            step_n = 1'b1;
          end
        end else begin
          tick_n = tick + ONE_D;
        end
      end

      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      tick     <= '0;
      interval <= ONE_D;
      steps    <= '0;
      face     <= '0;
      step     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      tick     <= tick_n;
      interval <= interval_n;
      steps    <= steps_n;
      face     <= face_n;
      step     <= step_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Bench for dice_roll_ctrl: four parameterisations driven one at a time through directed and random rolls.
// Expected outputs come from a roll-level model (face index arithmetic and interval schedule).
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_dice_roll_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic roll;
  int   sel;

  logic [3:0] face0, face1, face2, face3;
  logic       step0, step1, step2, step3;
  logic       busy0, busy1, busy2, busy3;
  logic       done0, done1, done2, done3;
  logic       roll0, roll1, roll2, roll3;

  // Only the selected instance sees roll; the others idle.
  assign roll0 = roll && (sel == 0);
  assign roll1 = roll && (sel == 1);
  assign roll2 = roll && (sel == 2);
  assign roll3 = roll && (sel == 3);

  dice_roll_ctrl dut0 (.clk(clk), .rst_n(rst_n), .roll(roll0), .face(face0), .step(step0), .busy(busy0), .done(done0));
  dice_roll_ctrl #(.FACES(3)) dut1 (.clk(clk), .rst_n(rst_n), .roll(roll1), .face(face1), .step(step1), .busy(busy1), .done(done1));
  dice_roll_ctrl #(.SLOW_STEPS(1), .DIV_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .roll(roll2), .face(face2), .step(step2), .busy(busy2), .done(done2));
  dice_roll_ctrl #(.FACES(5), .DIV_W(3)) dut3 (.clk(clk), .rst_n(rst_n), .roll(roll3), .face(face3), .step(step3), .busy(busy3), .done(done3));

  logic [3:0] cur_face;
  logic       cur_step, cur_busy, cur_done;

  // Present the selected instance's outputs to the checker.
  always_comb begin
    cur_face = face0; cur_step = step0; cur_busy = busy0; cur_done = done0;
    case (sel)
      1: begin cur_face = face1; cur_step = step1; cur_busy = busy1; cur_done = done1; end
      2: begin cur_face = face2; cur_step = step2; cur_busy = busy2; cur_done = done2; end
      3: begin cur_face = face3; cur_step = step3; cur_busy = busy3; cur_done = done3; end
      default: ;
    endcase
  end

  int p_faces [4] = '{6, 3, 6, 5};
  int p_steps [4] = '{4, 4, 1, 4};
  int p_divw  [4] = '{8, 8, 2, 3};

  int checks = 0;
  int errors = 0;
  int m_idx;
  int m_face;

  task automatic tick_chk(input string tag, input int ef, input bit es, input bit eb, input bit ed);
    logic [3:0] ef4;
    ef4 = 4'(ef);
    @(posedge clk);
    #1;
    checks++;
    assert (cur_face === ef4) else begin
      errors++;
      $error("FAIL %s face (dut %0d) got %0d expected %0d", tag, sel, cur_face, ef4);
    end
    checks++;
    assert (cur_step === es) else begin
      errors++;
      $error("FAIL %s step (dut %0d) got %b expected %b", tag, sel, cur_step, es);
    end
    checks++;
    assert (cur_busy === eb) else begin
      errors++;
      $error("FAIL %s busy (dut %0d) got %b expected %b", tag, sel, cur_busy, eb);
    end
    checks++;
    assert (cur_done === ed) else begin
      errors++;
      $error("FAIL %s done (dut %0d) got %b expected %b", tag, sel, cur_done, ed);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    roll  = 1'b0;
    tick_chk("reset", 0, 1'b0, 1'b0, 1'b0);
    rst_n  = 1'b1;
    m_idx  = 0;
    m_face = 0;
  endtask

  task automatic idle_cycles(input int n);
    roll = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick_chk("idle", m_face, 1'b0, 1'b0, 1'b0);
      m_idx = (m_idx + 1) % p_faces[sel];
    end
  endtask

  // One complete roll: IDLE edge, hold SPIN advances, slow-down, done, return to IDLE.
  // noisy toggles roll randomly during the slow-down; abort_at >= 0 resets that many cycles into it.
  task automatic do_roll(input int hold, input bit noisy, input int abort_at, input bit keep_roll);
    int f, s_max, d, iv, cap, cyc;
    f     = p_faces[sel];
    s_max = p_steps[sel];
    d     = p_divw[sel];
    cap   = 1 << (d - 1);
    roll  = 1'b1;
    tick_chk("idle_to_spin", m_face, 1'b0, 1'b1, 1'b0);
    m_idx = (m_idx + 1) % f;
    for (int k = 0; k < hold; k++) begin
      m_idx  = (m_idx + 1) % f;
      m_face = m_idx + 1;
      tick_chk("spin", m_face, 1'b1, 1'b1, 1'b0);
    end
    roll = 1'b0;
    tick_chk("slow_entry", m_face, 1'b0, 1'b1, 1'b0);
    cyc = 0;
    for (int s = 0; s < s_max; s++) begin
      iv = 1 << (s + 1);
      if (iv > cap) iv = cap;
      for (int c = 1; c <= iv; c++) begin
        if (noisy) roll = 1'($urandom_range(0, 1));
        if (cyc == abort_at) begin
          rst_n = 1'b0;
          roll  = 1'b0;
          tick_chk("abort_reset", 0, 1'b0, 1'b0, 1'b0);
          rst_n  = 1'b1;
          m_idx  = 0;
          m_face = 0;
          return;
        end
        cyc++;
        if (c < iv) begin
          tick_chk("slow_wait", m_face, 1'b0, 1'b1, 1'b0);
        end else begin
          m_idx  = (m_idx + 1) % f;
          m_face = m_idx + 1;
          if (s < s_max - 1) tick_chk("slow_adv", m_face, 1'b1, 1'b1, 1'b0);
          else               tick_chk("done", m_face, 1'b0, 1'b0, 1'b1);
        end
      end
    end
    roll = keep_roll;
    tick_chk("done_to_idle", m_face, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    sel   = 0;
    roll  = 1'b0;
    rst_n = 1'b0;

    // Reset held for two edges.
    tick_chk("reset", 0, 1'b0, 1'b0, 1'b0);
    tick_chk("reset", 0, 1'b0, 1'b0, 1'b0);
    rst_n  = 1'b1;
    m_idx  = 0;
    m_face = 0;

    // Basic roll straight out of reset: faces 6 then 1,2,3,4.
    do_roll(10, 1'b0, -1, 1'b0);
    idle_cycles($urandom_range(1, 5));

    // roll chatters during the slow-down: no restart, one done.
    do_roll($urandom_range(1, 12), 1'b1, -1, 1'b0);
    idle_cycles($urandom_range(0, 4));

    // Reset in mid slow-down, then a fresh roll from index 0.
    do_roll(8, 1'b0, 9, 1'b0);
    do_roll(10, 1'b0, -1, 1'b1);

    // roll held through done: one DONE cycle, one IDLE cycle, then SPIN.
    do_roll(3, 1'b0, -1, 1'b0);
    idle_cycles(2);

    // Three-face wrap-around: 3,1,2,3,1,2,3.
    sel = 1;
    do_reset();
    do_roll(7, 1'b0, -1, 1'b0);

    // Single slow advance with a 2-bit interval.
    sel = 2;
    do_reset();
    do_roll($urandom_range(1, 8), 1'b0, -1, 1'b0);

    // Interval saturation: spacing 2,4,4,4.
    sel = 3;
    do_reset();
    do_roll($urandom_range(1, 8), 1'b0, -1, 1'b0);

    // Random rolls across all instances.
    for (int i = 0; i < 8; i++) begin
      sel = $urandom_range(0, 3);
      do_reset();
      idle_cycles($urandom_range(0, 7));
      do_roll($urandom_range(0, 15), 1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)));
      idle_cycles($urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
